// File: rtl/gg_pkg.sv
// Shared types and phrase field layout for the slice phrase scheduler.
// A phrase packs len [8:0], a 512-bit bits field and a 512-bit mask field.
package gg_pkg;

  localparam int LEN_W       = 9;
  localparam int PH_DATA_W   = 512;
  localparam int PH_LEN_LSB  = 0;
  localparam int PH_BITS_LSB = PH_LEN_LSB + LEN_W;
  localparam int PH_MASK_LSB = PH_BITS_LSB + PH_DATA_W;
  localparam int PHRASE_W    = 1040;

  typedef logic [PHRASE_W-1:0] phrase_t;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    TRAIL,
    FLUSH
  } sched_state_t;

  function automatic logic [LEN_W-1:0] phrase_len(input phrase_t p);
    return p[PH_LEN_LSB +: LEN_W];
  endfunction

  // Unused top bits above the mask field are always packed as zero.
  function automatic phrase_t make_phrase(input logic [LEN_W-1:0]     len,
                                          input logic [PH_DATA_W-1:0] bits,
                                          input logic [PH_DATA_W-1:0] mask);
    phrase_t p;
    p = '0;
    p[PH_LEN_LSB  +: LEN_W]     = len;
    p[PH_BITS_LSB +: PH_DATA_W] = bits;
    p[PH_MASK_LSB +: PH_DATA_W] = mask;
    return p;
  endfunction

endpackage

// File: rtl/gg_slice_phrase_sched_if.sv
// Phrase channels between the entropy sources, the scheduler and the aligner.
// The slave modport is the scheduler's view; master is the surrounding environment.
interface gg_slice_phrase_sched_if;
  import gg_pkg::*;

  logic    hdr_valid;
  logic    hdr_ready;
  phrase_t hdr_phrase;
  logic    hdr_last;
  logic    hdr_dont_touch;

  logic    mb_valid;
  logic    mb_ready;
  phrase_t mb_phrase;
  logic    mb_last;
  logic    mb_byte_align;

  logic    out_valid;
  phrase_t out_phrase;
  logic    out_byte_align;
  logic    out_dont_touch;
  logic    out_flush;

  modport slave (
    input  hdr_valid, hdr_phrase, hdr_last, hdr_dont_touch,
    output hdr_ready,
    input  mb_valid, mb_phrase, mb_last, mb_byte_align,
    output mb_ready,
    output out_valid, out_phrase, out_byte_align, out_dont_touch, out_flush
  );

  modport master (
    output hdr_valid, hdr_phrase, hdr_last, hdr_dont_touch,
    input  hdr_ready,
    output mb_valid, mb_phrase, mb_last, mb_byte_align,
    input  mb_ready,
    input  out_valid, out_phrase, out_byte_align, out_dont_touch, out_flush
  );

endinterface

// File: rtl/gg_trail_phrase_gen.sv
// Builds the rbsp stop-bit/alignment phrase: a single 1 followed by zeros up to
// the next byte boundary, given the low three bits of the current bit position.
module gg_trail_phrase_gen
  import gg_pkg::*;
(
  input  logic [2:0] bit_low,
  output phrase_t    phrase
);

  logic [3:0] t_len;
  logic [7:0] bits8;
  logic [7:0] mask8;

  // t_len is 1..8, so the shifts below never leave the low byte.
  always_comb begin
    t_len  = 4'd8 - {1'b0, bit_low};
    bits8  = 8'd1 << (t_len - 4'd1);
    mask8  = 8'((9'd1 << t_len) - 9'd1);
    phrase = make_phrase(LEN_W'(t_len), PH_DATA_W'(bits8), PH_DATA_W'(mask8));
  end

endmodule

// File: rtl/gg_slice_phrase_sched.sv
// Slice phrase scheduler: header phrases, then macroblock phrases, then a trail
// phrase and a flush, while tracking bit position and completed 512-bit words.
module gg_slice_phrase_sched
  import gg_pkg::*;
#(
  parameter int FLUSH_CYC = 2,
  parameter int WCNT_W    = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   slice_start,
  output logic                   slice_busy,
  output logic                   slice_done,
  gg_slice_phrase_sched_if.slave phr,
  output logic [LEN_W-1:0]       bit_pos,
  output logic [WCNT_W-1:0]      word_count
);

  localparam int FCNT_W = $clog2(FLUSH_CYC + 1);
  localparam logic [LEN_W:0] ALIGN_M = (LEN_W+1)'(7);

  sched_state_t      state_q;
  sched_state_t      state_d;
  logic [FCNT_W-1:0] flush_cnt;
  logic              flush_last;
  logic              flush_first;
  logic              hdr_acc;
  logic              mb_acc;
  logic              trail_emit;
  logic              emit;
  logic              emit_align;
  logic [LEN_W-1:0]  emit_len;
  logic [LEN_W:0]    pos_sum;
  phrase_t           trail_phrase;

  gg_trail_phrase_gen u_trail (
    .bit_low (bit_pos[2:0]),
    .phrase  (trail_phrase)
  );

  assign hdr_acc     = phr.hdr_valid && (state_q == HDR);
  assign mb_acc      = phr.mb_valid && (state_q == DATA);
  assign trail_emit  = (state_q == TRAIL);
  assign flush_last  = (flush_cnt == FCNT_W'(FLUSH_CYC - 1));
  assign flush_first = (state_q == FLUSH) && (flush_cnt == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (slice_start) state_d = HDR;
      HDR:     if (hdr_acc && phr.hdr_last) state_d = DATA;
      DATA:    if (mb_acc && phr.mb_last) state_d = TRAIL;
      TRAIL:   state_d = FLUSH;
      FLUSH:   if (flush_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Ready depends on state alone so sources can never form a loop through valid.
  always_comb begin
    phr.hdr_ready = (state_q == HDR);
    phr.mb_ready  = (state_q == DATA);
    slice_busy    = (state_q != IDLE);
    slice_done    = (state_q == FLUSH) && flush_last;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flush_cnt <= '0;
    end else if (state_q == FLUSH) begin
      flush_cnt <= flush_cnt + FCNT_W'(1);
    end else begin
      flush_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phr.out_valid      <= 1'b0;
      phr.out_phrase     <= '0;
      phr.out_byte_align <= 1'b0;
      phr.out_dont_touch <= 1'b0;
      phr.out_flush      <= 1'b0;
    end else begin
      phr.out_flush <= (state_q == FLUSH);
      if (hdr_acc) begin
        phr.out_valid      <= 1'b1;
        phr.out_phrase     <= phr.hdr_phrase;
        phr.out_byte_align <= 1'b0;
        phr.out_dont_touch <= phr.hdr_dont_touch;
      end else if (mb_acc) begin
        phr.out_valid      <= 1'b1;
        phr.out_phrase     <= phr.mb_phrase;
        phr.out_byte_align <= phr.mb_byte_align;
        phr.out_dont_touch <= 1'b0;
      end else if (trail_emit) begin
        phr.out_valid      <= 1'b1;
        phr.out_phrase     <= trail_phrase;
        phr.out_byte_align <= 1'b0;
        phr.out_dont_touch <= 1'b0;
      end else begin
        phr.out_valid      <= 1'b0;
        phr.out_byte_align <= 1'b0;
        phr.out_dont_touch <= 1'b0;
      end
    end
  end

  // The carry out of the 10-bit sum is exactly one completed 512-bit word.
  always_comb begin
    emit       = 1'b0;
    emit_len   = '0;
    emit_align = 1'b0;
    if (hdr_acc) begin
      emit     = 1'b1;
      emit_len = phrase_len(phr.hdr_phrase);
    end else if (mb_acc) begin
      emit       = 1'b1;
      emit_len   = phrase_len(phr.mb_phrase);
      emit_align = phr.mb_byte_align;
    end else if (trail_emit) begin
      emit     = 1'b1;
      emit_len = phrase_len(trail_phrase);
    end
    pos_sum = {1'b0, bit_pos} + {1'b0, emit_len};
    if (emit_align) begin
      pos_sum = (pos_sum + ALIGN_M) & ~ALIGN_M;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_pos    <= '0;
      word_count <= '0;
    end else if (emit) begin
      bit_pos    <= pos_sum[LEN_W-1:0];
      word_count <= word_count + WCNT_W'(pos_sum[LEN_W]);
    end else if (flush_first && (bit_pos != '0)) begin
      bit_pos    <= '0;
      word_count <= word_count + WCNT_W'(1);
    end
  end

endmodule

// File: tb/tb_gg_slice_phrase_sched.sv
// Directed bench for the slice phrase scheduler: a vector table for three slices
// plus hand-written reset sequences.
module tb_gg_slice_phrase_sched;
  import gg_pkg::*;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              slice_start;
  logic              slice_busy;
  logic              slice_done;
  logic [LEN_W-1:0]  bit_pos;
  logic [31:0]       word_count;

  int pass_cnt  = 0;
  int total_cnt = 0;

  gg_slice_phrase_sched_if phr ();

  gg_slice_phrase_sched #(
    .FLUSH_CYC (2),
    .WCNT_W    (32)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .slice_start (slice_start),
    .slice_busy  (slice_busy),
    .slice_done  (slice_done),
    .phr         (phr.slave),
    .bit_pos     (bit_pos),
    .word_count  (word_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int start, hv, hl, hlast, hdt, mv, ml, mlast, malign;
    int ev, elen;
    int unsigned ebits, emask;
    int ealign, edt, eflush, ebp, ewc, ebusy, edone, ehr, emr;
  } vec_t;

  vec_t vecs [23];

  function automatic phrase_t mk(input int len);
    return make_phrase(LEN_W'(len), PH_DATA_W'(32'hC0DE0000 | 32'(len)),
                       PH_DATA_W'(32'hFFFFFFFF));
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) begin
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  task automatic idleInputs();
    slice_start        = 1'b0;
    phr.hdr_valid      = 1'b0;
    phr.hdr_phrase     = '0;
    phr.hdr_last       = 1'b0;
    phr.hdr_dont_touch = 1'b0;
    phr.mb_valid       = 1'b0;
    phr.mb_phrase      = '0;
    phr.mb_last        = 1'b0;
    phr.mb_byte_align  = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    slice_start        = (v.start != 0);
    phr.hdr_valid      = (v.hv != 0);
    phr.hdr_phrase     = mk(v.hl);
    phr.hdr_last       = (v.hlast != 0);
    phr.hdr_dont_touch = (v.hdt != 0);
    phr.mb_valid       = (v.mv != 0);
    phr.mb_phrase      = mk(v.ml);
    phr.mb_last        = (v.mlast != 0);
    phr.mb_byte_align  = (v.malign != 0);
    tick();
  endtask

  task automatic checkVector(input int idx, input vec_t v);
    string p;
    phrase_t exp_ph;
    p = $sformatf("v%0d.", idx);
    checkOutput({p, "out_valid"},  64'(phr.out_valid),  64'(v.ev));
    checkOutput({p, "out_flush"},  64'(phr.out_flush),  64'(v.eflush));
    checkOutput({p, "bit_pos"},    64'(bit_pos),        64'(v.ebp));
    checkOutput({p, "word_count"}, 64'(word_count),     64'(v.ewc));
    checkOutput({p, "slice_busy"}, 64'(slice_busy),     64'(v.ebusy));
    checkOutput({p, "slice_done"}, 64'(slice_done),     64'(v.edone));
    checkOutput({p, "hdr_ready"},  64'(phr.hdr_ready),  64'(v.ehr));
    checkOutput({p, "mb_ready"},   64'(phr.mb_ready),   64'(v.emr));
    if (v.ev != 0) begin
      exp_ph = make_phrase(LEN_W'(v.elen), PH_DATA_W'(v.ebits), PH_DATA_W'(v.emask));
      checkOutput({p, "len"},  64'(phr.out_phrase[PH_LEN_LSB +: LEN_W]), 64'(v.elen));
      checkOutput({p, "bits"}, 64'(phr.out_phrase[PH_BITS_LSB +: 32]),   64'(v.ebits));
      checkOutput({p, "mask"}, 64'(phr.out_phrase[PH_MASK_LSB +: 32]),   64'(v.emask));
      checkOutput({p, "phrase_equal"}, 64'(phr.out_phrase == exp_ph),   64'd1);
      checkOutput({p, "byte_align"}, 64'(phr.out_byte_align), 64'(v.ealign));
      checkOutput({p, "dont_touch"}, 64'(phr.out_dont_touch), 64'(v.edt));
    end
  endtask

  initial begin
    // start hv hl hlast hdt mv ml mlast malign | ev elen ebits emask ealign edt eflush ebp ewc busy done hrdy mrdy
    vecs[0]  = '{1,0,0,0,0, 0,0,0,0,   0,0,  32'h0,        32'h0,        0,0,0, 0,  0, 1,0,1,0};
    vecs[1]  = '{0,1,24,1,1, 0,0,0,0,  1,24, 32'hC0DE0018, 32'hFFFFFFFF, 0,1,0, 24, 0, 1,0,0,1};
    vecs[2]  = '{0,0,0,0,0, 1,100,0,0, 1,100,32'hC0DE0064, 32'hFFFFFFFF, 0,0,0, 124,0, 1,0,0,1};
    vecs[3]  = '{0,0,0,0,0, 1,5,1,0,   1,5,  32'hC0DE0005, 32'hFFFFFFFF, 0,0,0, 129,0, 1,0,0,0};
    vecs[4]  = '{0,0,0,0,0, 0,0,0,0,   1,7,  32'h00000040, 32'h0000007F, 0,0,0, 136,0, 1,0,0,0};
    vecs[5]  = '{0,0,0,0,0, 0,0,0,0,   0,0,  32'h0,        32'h0,        0,0,1, 0,  1, 1,1,0,0};
    vecs[6]  = '{1,0,0,0,0, 0,0,0,0,   0,0,  32'h0,        32'h0,        0,0,1, 0,  1, 0,0,0,0};
    vecs[7]  = '{0,0,0,0,0, 0,0,0,0,   0,0,  32'h0,        32'h0,        0,0,0, 0,  1, 0,0,0,0};
    vecs[8]  = '{1,0,0,0,0, 0,0,0,0,   0,0,  32'h0,        32'h0,        0,0,0, 0,  1, 1,0,1,0};
    vecs[9]  = '{0,1,24,1,0, 0,0,0,0,  1,24, 32'hC0DE0018, 32'hFFFFFFFF, 0,0,0, 24, 1, 1,0,0,1};
    vecs[10] = '{0,0,0,0,0, 1,3,0,1,   1,3,  32'hC0DE0003, 32'hFFFFFFFF, 1,0,0, 32, 1, 1,0,0,1};
    vecs[11] = '{0,0,0,0,0, 1,0,1,0,   1,0,  32'hC0DE0000, 32'hFFFFFFFF, 0,0,0, 32, 1, 1,0,0,0};
    vecs[12] = '{0,0,0,0,0, 0,0,0,0,   1,8,  32'h00000080, 32'h000000FF, 0,0,0, 40, 1, 1,0,0,0};
    vecs[13] = '{0,0,0,0,0, 0,0,0,0,   0,0,  32'h0,        32'h0,        0,0,1, 0,  2, 1,1,0,0};
    vecs[14] = '{0,0,0,0,0, 0,0,0,0,   0,0,  32'h0,        32'h0,        0,0,1, 0,  2, 0,0,0,0};
    vecs[15] = '{1,0,0,0,0, 0,0,0,0,   0,0,  32'h0,        32'h0,        0,0,0, 0,  2, 1,0,1,0};
    vecs[16] = '{0,0,0,0,0, 1,20,1,0,  0,0,  32'h0,        32'h0,        0,0,0, 0,  2, 1,0,1,0};
    vecs[17] = '{0,1,500,1,0, 1,20,1,0,1,500,32'hC0DE01F4, 32'hFFFFFFFF, 0,0,0, 500,2, 1,0,0,1};
    vecs[18] = '{1,0,0,0,0, 1,20,0,0,  1,20, 32'hC0DE0014, 32'hFFFFFFFF, 0,0,0, 8,  3, 1,0,0,1};
    vecs[19] = '{0,0,0,0,0, 1,0,1,0,   1,0,  32'hC0DE0000, 32'hFFFFFFFF, 0,0,0, 8,  3, 1,0,0,0};
    vecs[20] = '{0,0,0,0,0, 0,0,0,0,   1,8,  32'h00000080, 32'h000000FF, 0,0,0, 16, 3, 1,0,0,0};
    vecs[21] = '{0,0,0,0,0, 0,0,0,0,   0,0,  32'h0,        32'h0,        0,0,1, 0,  4, 1,1,0,0};
    vecs[22] = '{0,0,0,0,0, 0,0,0,0,   0,0,  32'h0,        32'h0,        0,0,1, 0,  4, 0,0,0,0};

    idleInputs();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (10) tick();
    checkOutput("rst.out_valid",  64'(phr.out_valid),      64'd0);
    checkOutput("rst.out_flush",  64'(phr.out_flush),      64'd0);
    checkOutput("rst.byte_align", 64'(phr.out_byte_align), 64'd0);
    checkOutput("rst.dont_touch", 64'(phr.out_dont_touch), 64'd0);
    checkOutput("rst.phrase_zero", 64'(phr.out_phrase == '0), 64'd1);
    checkOutput("rst.bit_pos",    64'(bit_pos),            64'd0);
    checkOutput("rst.word_count", 64'(word_count),         64'd0);
    checkOutput("rst.slice_busy", 64'(slice_busy),         64'd0);
    checkOutput("rst.slice_done", 64'(slice_done),         64'd0);
    checkOutput("rst.hdr_ready",  64'(phr.hdr_ready),      64'd0);
    checkOutput("rst.mb_ready",   64'(phr.mb_ready),       64'd0);

    for (int i = 0; i < 23; i++) begin
      applyStimulus(vecs[i]);
      checkVector(i, vecs[i]);
    end
    idleInputs();

    // Asynchronous reset in the middle of a slice while a phrase is on the output.
    slice_start = 1'b1;
    tick();
    slice_start        = 1'b0;
    phr.hdr_valid      = 1'b1;
    phr.hdr_phrase     = mk(24);
    phr.hdr_last       = 1'b1;
    tick();
    idleInputs();
    phr.mb_valid  = 1'b1;
    phr.mb_phrase = mk(8);
    tick();
    idleInputs();
    checkOutput("mid.pre_out_valid",  64'(phr.out_valid), 64'd1);
    checkOutput("mid.pre_bit_pos",    64'(bit_pos),       64'd32);
    checkOutput("mid.pre_word_count", 64'(word_count),    64'd4);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("mid.out_valid",  64'(phr.out_valid),  64'd0);
    checkOutput("mid.bit_pos",    64'(bit_pos),        64'd0);
    checkOutput("mid.word_count", 64'(word_count),     64'd0);
    checkOutput("mid.slice_busy", 64'(slice_busy),     64'd0);
    checkOutput("mid.mb_ready",   64'(phr.mb_ready),   64'd0);
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    checkOutput("post.out_valid", 64'(phr.out_valid), 64'd0);
    checkOutput("post.slice_busy", 64'(slice_busy),   64'd0);
    checkOutput("post.bit_pos",   64'(bit_pos),       64'd0);
    checkOutput("post.out_flush", 64'(phr.out_flush), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
